// File: rtl/sc_loadcounter.sv
// Loadable up-counter with prescaled, coalescing increment requests.
// Priority at each edge: clear, load, increment.
module sc_loadcounter #(
  parameter int unsigned DATAWIDTH      = 8,
  parameter int unsigned PRESCALE_COUNT = 50,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                 SC_LOADCOUNTER_CLOCK_50,
  input  logic                 SC_LOADCOUNTER_RESET_InHigh,
  input  logic                 SC_LOADCOUNTER_clear_InHigh,
  input  logic                 SC_LOADCOUNTER_load_InLow,
  input  logic                 SC_LOADCOUNTER_upcount_InLow,
  input  logic [DATAWIDTH-1:0] SC_LOADCOUNTER_data_InBUS,
  input  logic [DATAWIDTH-1:0] SC_LOADCOUNTER_limit_InBUS,
  output logic [DATAWIDTH-1:0] SC_LOADCOUNTER_data_OutBUS,
  output logic                 SC_LOADCOUNTER_FLAG_OutLow,
  output logic                 SC_LOADCOUNTER_tick_OutHigh,
  output logic                 SC_LOADCOUNTER_wrap_OutHigh
);

  localparam logic [PRESCALE_WIDTH-1:0] PrescaleLast = PRESCALE_WIDTH'(PRESCALE_COUNT - 1);

  logic [DATAWIDTH-1:0]      count_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      pending_q;
  logic                      wrap_q;
  logic                      tick;
  logic                      increment;

  assign tick      = (presc_q == PrescaleLast);
  // A request is honoured either from the pending latch or directly on a tick cycle.
  assign increment = tick && (pending_q || !SC_LOADCOUNTER_upcount_InLow);

  always_ff @(posedge SC_LOADCOUNTER_CLOCK_50 or posedge SC_LOADCOUNTER_RESET_InHigh) begin
    if (SC_LOADCOUNTER_RESET_InHigh) begin
      count_q   <= '0;
      presc_q   <= '0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (SC_LOADCOUNTER_clear_InHigh) begin
      count_q   <= '0;
      presc_q   <= '0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (!SC_LOADCOUNTER_load_InLow) begin
        count_q   <= SC_LOADCOUNTER_data_InBUS;
        pending_q <= 1'b0;
        wrap_q    <= 1'b0;
      end else if (increment) begin
        count_q   <= count_q + 1'b1;
        pending_q <= 1'b0;
        wrap_q    <= &count_q;
      end else begin
        wrap_q <= 1'b0;
        if (!SC_LOADCOUNTER_upcount_InLow) begin
          pending_q <= 1'b1;
        end
      end
    end
  end

  assign SC_LOADCOUNTER_data_OutBUS  = count_q;
  assign SC_LOADCOUNTER_FLAG_OutLow  = (count_q != SC_LOADCOUNTER_limit_InBUS);
  assign SC_LOADCOUNTER_tick_OutHigh = tick;
  assign SC_LOADCOUNTER_wrap_OutHigh = wrap_q;

endmodule

// File: tb/tb_sc_loadcounter.sv
// Self-checking bench for sc_loadcounter against a cycle-level arithmetic reference model.
module tb_sc_loadcounter;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       ld_n = 1'b1;
  logic       up_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic [7:0] limit = 8'h00;
  logic [7:0] dout;
  logic       flag_n;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_count = 0;
  int m_pend  = 0;
  int m_presc = 0;
  int m_wrap  = 0;

  sc_loadcounter #(
    .DATAWIDTH     (8),
    .PRESCALE_COUNT(P),
    .PRESCALE_WIDTH(2)
  ) dut (
    .SC_LOADCOUNTER_CLOCK_50     (clk),
    .SC_LOADCOUNTER_RESET_InHigh (rst),
    .SC_LOADCOUNTER_clear_InHigh (clr),
    .SC_LOADCOUNTER_load_InLow   (ld_n),
    .SC_LOADCOUNTER_upcount_InLow(up_n),
    .SC_LOADCOUNTER_data_InBUS   (data),
    .SC_LOADCOUNTER_limit_InBUS  (limit),
    .SC_LOADCOUNTER_data_OutBUS  (dout),
    .SC_LOADCOUNTER_FLAG_OutLow  (flag_n),
    .SC_LOADCOUNTER_tick_OutHigh (tick),
    .SC_LOADCOUNTER_wrap_OutHigh (wrap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0; m_pend = 0; m_presc = 0; m_wrap = 0;
  endtask

  // Drive one cycle of inputs from a negedge, update the model at the posedge, return at negedge.
  task automatic step(input logic c, input logic l, input logic u, input logic [7:0] d);
    bit tick_now;
    clr = c; ld_n = l; up_n = u; data = d;
    @(posedge clk);
    tick_now = (m_presc == P - 1);
    if (c) begin
      model_reset();
    end else begin
      m_presc = (m_presc + 1) % P;
      if (!l) begin
        m_count = d; m_pend = 0; m_wrap = 0;
      end else if (tick_now && (m_pend == 1 || !u)) begin
        m_wrap  = (m_count == 255) ? 1 : 0;
        m_count = (m_count + 1) % 256;
        m_pend  = 0;
      end else begin
        m_wrap = 0;
        if (!u) m_pend = 1;
      end
    end
    @(negedge clk);
    clr = 1'b0; ld_n = 1'b1; up_n = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < P && m_presc != phase; i++) idle();
  endtask

  task automatic test_reset();
    idle();
    step(1'b0, 1'b0, 1'b1, 8'h37);
    align(0);
    step(1'b0, 1'b1, 1'b0, 8'h00);  // pending set, count still 0x37
    limit = 8'h09;
    checks++;
    if (dout !== 8'h37) begin
      failures++; $display("FAIL reset_precount: got %h want 37", dout);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dout !== 8'h00 || tick !== 1'b0 || flag_n !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: count=%h tick=%b flag=%b wrap=%b want 00 0 1 0",
               dout, tick, flag_n, wrap);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < P; i++) idle();  // lost pending request must not increment
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL reset_pending_lost: got %h want 00", dout);
    end
  endtask

  task automatic test_load();
    align(1);
    step(1'b0, 1'b0, 1'b1, 8'hF0);
    checks++;
    if (dout !== 8'hF0 || tick !== 1'b0) begin
      failures++; $display("FAIL load_value: count=%h tick=%b want f0 0", dout, tick);
    end
    idle();
    checks++;
    if (tick !== 1'b1 || dout !== 8'hF0) begin
      failures++; $display("FAIL load_phase: tick=%b count=%h want 1 f0", tick, dout);
    end
  endtask

  task automatic test_upcount_latency();
    logic [7:0] start;
    align(0);
    start = dout;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(); idle();
    checks++;
    if (dout !== start) begin
      failures++; $display("FAIL upcount_early: got %h want %h", dout, start);
    end
    idle();
    checks++;
    if (dout !== start + 8'd1) begin
      failures++; $display("FAIL upcount_latency: got %h want %h", dout, start + 8'd1);
    end
    align(0);
    start = dout;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    for (int i = 0; i < P; i++) idle();
    checks++;
    if (dout !== start + 8'd1) begin
      failures++; $display("FAIL upcount_coalesce: got %h want %h", dout, start + 8'd1);
    end
  endtask

  task automatic test_wrap();
    align(0);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    checks++;
    if (dout !== 8'hFF || wrap !== 1'b0) begin
      failures++; $display("FAIL wrap_before: count=%h wrap=%b want ff 0", dout, wrap);
    end
    idle();
    checks++;
    if (dout !== 8'h00 || wrap !== 1'b1) begin
      failures++; $display("FAIL wrap_pulse: count=%h wrap=%b want 00 1", dout, wrap);
    end
    idle();
    checks++;
    if (wrap !== 1'b0) begin
      failures++; $display("FAIL wrap_single: wrap=%b want 0", wrap);
    end
  endtask

  task automatic test_flag();
    limit = 8'h05;
    align(0);
    step(1'b0, 1'b0, 1'b1, 8'h04);
    checks++;
    if (flag_n !== 1'b1) begin
      failures++; $display("FAIL flag_not_equal: flag=%b want 1", flag_n);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    checks++;
    if (dout !== 8'h04 || flag_n !== 1'b1) begin
      failures++; $display("FAIL flag_pre: count=%h flag=%b want 04 1", dout, flag_n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout !== 8'h05 || flag_n !== 1'b0) begin
      failures++; $display("FAIL flag_same_cycle: count=%h flag=%b want 05 0", dout, flag_n);
    end
    m_count = 5; m_presc = 0; m_pend = 0; m_wrap = 0;
    @(negedge clk);
    limit = 8'h06;
    #1;
    checks++;
    if (flag_n !== 1'b1) begin
      failures++; $display("FAIL flag_limit_change: flag=%b want 1", flag_n);
    end
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, 1'b1, 8'h20);
    align(P - 1);
    step(1'b1, 1'b0, 1'b0, 8'h77);
    checks++;
    if (dout !== 8'h00 || wrap !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL clear_priority: count=%h wrap=%b tick=%b want 00 0 0", dout, wrap, tick);
    end
    for (int i = 0; i < P + 1; i++) idle();
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL clear_pending: count=%h want 00", dout);
    end
  endtask

  task automatic test_random();
    logic c, l, u;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 7) != 0);
      u = ($urandom_range(0, 1) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom);
      if ($urandom_range(0, 15) == 0) limit = 8'($urandom);
      step(c, l, u, d);
      checks++;
      if (dout !== 8'(m_count) || wrap !== 1'(m_wrap) || tick !== (m_presc == P - 1)
          || flag_n !== (8'(m_count) != limit)) begin
        failures++;
        $display("FAIL random[%0d]: count=%h wrap=%b tick=%b flag=%b want %h %0d %0d %0d",
                 i, dout, wrap, tick, flag_n, 8'(m_count), m_wrap, (m_presc == P - 1),
                 (8'(m_count) != limit));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (dout !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || flag_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%h tick=%b wrap=%b flag=%b want 00 0 0 0",
               dout, tick, wrap, flag_n);
    end
    test_reset();
    test_load();
    test_upcount_latency();
    test_wrap();
    test_flag();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
